// File: rtl/astro_game_ctrl.sv
// AstroBarrier game sequencer: level flow, single-bullet fire arbitration,
// per-level target hit tracking, BCD score with end-of-level shot bonus.
module astro_game_ctrl #(
    parameter int SHOTS_PER_LEVEL = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       fire_req,
    input  logic       hit_valid,
    input  logic [1:0] hit_id,
    input  logic       miss,
    output logic [1:0] state,
    output logic       fire_grant,
    output logic       bullet_busy,
    output logic       level_load,
    output logic [2:0] hit_mask,
    output logic [3:0] shots_left,
    output logic [7:0] score_bcd,
    output logic       tallying,
    output logic       win
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [3:0] SHOTS_INIT = 4'(SHOTS_PER_LEVEL);

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t     state_q, state_d;
    logic       fire_prev_q, fire_prev_d;
    logic       fire_grant_q, fire_grant_d;
    logic       bullet_busy_q, bullet_busy_d;
    logic       level_load_q, level_load_d;
    logic [2:0] hit_mask_q, hit_mask_d;
    logic [3:0] shots_left_q, shots_left_d;
    logic [7:0] score_q, score_d;
    logic       tallying_q, tallying_d;
    logic       win_q, win_d;

    logic [2:0] level_set;
    logic [2:0] hit_bit;
    logic       level_done;
    logic       fire_edge;
    logic       hit_ok;

    always_comb begin
        state_d       = state_q;
        fire_prev_d   = fire_req;
        fire_grant_d  = 1'b0;
        bullet_busy_d = bullet_busy_q;
        level_load_d  = 1'b0;
        hit_mask_d    = hit_mask_q;
        shots_left_d  = shots_left_q;
        score_d       = score_q;
        tallying_d    = tallying_q;
        win_d         = win_q;

        level_set  = (state_q == QGAME_2) ? 3'b111 : 3'b011;
        level_done = (hit_mask_q == level_set);
        fire_edge  = fire_req & ~fire_prev_q;
        // Out-of-range id 3 shifts out to an empty mask.
        hit_bit    = 3'b001 << hit_id;
        hit_ok     = (hit_id != 2'd3) && ((state_q == QGAME_2) || !hit_id[1]);

        case (state_q)
            QI: begin
                if (start) begin
                    state_d       = QGAME_1;
                    level_load_d  = 1'b1;
                    shots_left_d  = SHOTS_INIT;
                    hit_mask_d    = 3'b000;
                    score_d       = 8'h00;
                    win_d         = 1'b0;
                    bullet_busy_d = 1'b0;
                end
            end
            QGAME_1, QGAME_2: begin
                if (tallying_q) begin
                    if (shots_left_q != 4'd0) begin
                        shots_left_d = shots_left_q - 4'd1;
                        score_d      = bcd_inc(score_q);
                    end else begin
                        tallying_d = 1'b0;
                        if (state_q == QGAME_1) begin
                            state_d      = QGAME_2;
                            level_load_d = 1'b1;
                            shots_left_d = SHOTS_INIT;
                            hit_mask_d   = 3'b000;
                        end else begin
                            state_d = QDONE;
                            win_d   = 1'b1;
                        end
                    end
                end else if (!start) begin
                    state_d       = QI;
                    bullet_busy_d = 1'b0;
                end else if (level_done) begin
                    tallying_d = 1'b1;
                end else if (shots_left_q == 4'd0 && !bullet_busy_q) begin
                    state_d = QDONE;
                    win_d   = 1'b0;
                end else if (bullet_busy_q) begin
                    // A hit takes precedence over a simultaneous miss.
                    if (hit_valid) begin
                        bullet_busy_d = 1'b0;
                        if (hit_ok && ((hit_mask_q & hit_bit) == 3'b000)) begin
                            hit_mask_d = hit_mask_q | hit_bit;
                            score_d    = bcd_inc(score_q);
                        end
                    end else if (miss) begin
                        bullet_busy_d = 1'b0;
                    end
                end else if (fire_edge) begin
                    fire_grant_d  = 1'b1;
                    bullet_busy_d = 1'b1;
                    shots_left_d  = shots_left_q - 4'd1;
                end
            end
            QDONE: begin
                if (!start) state_d = QI;
            end
            default: state_d = QI;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= QI;
            fire_prev_q   <= 1'b0;
            fire_grant_q  <= 1'b0;
            bullet_busy_q <= 1'b0;
            level_load_q  <= 1'b0;
            hit_mask_q    <= 3'b000;
            shots_left_q  <= 4'd0;
            score_q       <= 8'h00;
            tallying_q    <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fire_prev_q   <= fire_prev_d;
            fire_grant_q  <= fire_grant_d;
            bullet_busy_q <= bullet_busy_d;
            level_load_q  <= level_load_d;
            hit_mask_q    <= hit_mask_d;
            shots_left_q  <= shots_left_d;
            score_q       <= score_d;
            tallying_q    <= tallying_d;
            win_q         <= win_d;
        end
    end

    assign state       = state_q;
    assign fire_grant  = fire_grant_q;
    assign bullet_busy = bullet_busy_q;
    assign level_load  = level_load_q;
    assign hit_mask    = hit_mask_q;
    assign shots_left  = shots_left_q;
    assign score_bcd   = score_q;
    assign tallying    = tallying_q;
    assign win         = win_q;

endmodule
